// File: rtl/matrix_dsp_sequencer.sv
// Fetch/issue/wait controller that drives UNIT_COUNT Matrix DSP units in lock-step from a shared PC.
// Optional per-instruction watchdog: define MATRIX_DSP_SEQ_WATCHDOG_EN.
module matrix_dsp_sequencer #(
  parameter int unsigned UNIT_COUNT     = 4,
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PC_WIDTH-1:0]      entryPoint,
  input  logic [127:0]             vectorIn,
  input  logic                     vectorLoad,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [PC_WIDTH-1:0]      programCounter,
  output logic                     instructionGrab,
  output logic                     submit,
  input  logic [UNIT_COUNT-1:0]    unitReady,
  input  logic [UNIT_COUNT-1:0]    unitProgramReady,
  output logic [127:0]             vector,
  input  logic [32*UNIT_COUNT-1:0] unitResult,
  output logic [32*UNIT_COUNT-1:0] resultOut
);
  localparam int unsigned VEC_W = 128;
  localparam int unsigned RES_W = 32 * UNIT_COUNT;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_HOLDOFF, S_WAIT, S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                grab_q, grab_d;
  logic                submit_q, submit_d;
  logic                hold_q, hold_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [VEC_W-1:0]    vector_q, vector_d;
  logic [RES_W-1:0]    result_q, result_d;

  logic all_ready_c, all_end_c, any_end_c, pc_max_c, timeout_c, err_set_c;

  assign all_ready_c = &unitReady;
  assign all_end_c   = &unitProgramReady;
  assign any_end_c   = |unitProgramReady;
  assign pc_max_c    = (pc_q == {PC_WIDTH{1'b1}});

`ifdef MATRIX_DSP_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Counts only while stalled on units; every other state restarts it from zero.
  always_comb begin
    wd_d = '0;
    if (state_q == S_DECODE || state_q == S_WAIT) wd_d = wd_q + WD_W'(1);
  end

  assign timeout_c = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  logic unused_timeout;
  assign timeout_c      = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    err_set_c = 1'b0;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (all_end_c) begin
          state_d = S_FINISH;
        end else if (any_end_c) begin
          state_d   = S_FINISH;
          err_set_c = 1'b1;
        end else if (all_ready_c) begin
          state_d = S_ISSUE;
        end else if (timeout_c) begin
          state_d   = S_FINISH;
          err_set_c = 1'b1;
        end
      end
      S_ISSUE:   state_d = S_HOLDOFF;
      S_HOLDOFF: if (hold_q) state_d = S_WAIT;
      S_WAIT: begin
        if (all_ready_c) begin
          state_d   = pc_max_c ? S_FINISH : S_FETCH;
          err_set_c = pc_max_c;
        end else if (timeout_c) begin
          state_d   = S_FINISH;
          err_set_c = 1'b1;
        end
      end
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; strobes are decoded from the next state so they register into place.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FINISH);
    grab_d   = (state_d == S_FETCH);
    submit_d = (state_d == S_ISSUE);
    hold_d   = (state_q == S_HOLDOFF);
    pc_d     = pc_q;
    error_d  = error_q;
    vector_d = vector_q;
    result_d = result_q;
    if (state_q == S_IDLE) begin
      if (vectorLoad) vector_d = vectorIn;
      if (start) begin
        pc_d    = entryPoint;
        error_d = 1'b0;
      end
    end
    if (err_set_c) error_d = 1'b1;
    if (state_q == S_WAIT && state_d == S_FETCH) pc_d = pc_q + PC_WIDTH'(1);
    if (state_q == S_FINISH) result_d = unitResult;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      grab_q   <= 1'b0;
      submit_q <= 1'b0;
      hold_q   <= 1'b0;
      pc_q     <= '0;
      vector_q <= '0;
      result_q <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      grab_q   <= grab_d;
      submit_q <= submit_d;
      hold_q   <= hold_d;
      pc_q     <= pc_d;
      vector_q <= vector_d;
      result_q <= result_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign instructionGrab = grab_q;
  assign submit          = submit_q;
  assign programCounter  = pc_q;
  assign vector          = vector_q;
  assign resultOut       = result_q;

endmodule
